// File: rtl/store_align.sv
// store_align: turns byte/half/word stores at any byte address into lane-positioned
// word writes. A store that spills past a word boundary is either split into two
// writes (SPLIT_EN=1) or dropped with an error pulse (SPLIT_EN=0).
module store_align #(
    parameter int unsigned SPLIT_EN = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wbe,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StWr0, StWr1, StFin} state_e;

    localparam logic [1:0] TypeSb  = 2'b00;
    localparam logic [1:0] TypeSh  = 2'b01;
    localparam logic [1:0] TypeSw  = 2'b10;
    localparam logic [1:0] TypeRsv = 2'b11;

    state_e      state_q, state_d;
    logic [1:0]  type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    // 8-bit lane mask spanning the addressed word and the next one.
    function automatic logic [7:0] lane_mask(input logic [1:0] t, input logic [1:0] off);
        logic [7:0] base;
        case (t)
            TypeSb:  base = 8'h01;
            TypeSh:  base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    logic [7:0]  req_mask;
    logic        req_cross;
    logic        req_drop;
    logic        accept;
    logic [7:0]  cur_mask;
    logic        cur_cross;
    logic [1:0]  cur_off;
    logic [31:0] word_base;

    // Decode the incoming request and the captured request.
    always_comb begin
        req_mask  = lane_mask(req_type, req_addr[1:0]);
        req_cross = |req_mask[7:4];
        req_drop  = (req_type == TypeRsv) || (req_cross && (SPLIT_EN == 0));
        req_ready = (state_q == StIdle) && !RST;
        accept    = req_valid && req_ready;
        cur_off   = addr_q[1:0];
        cur_mask  = lane_mask(type_q, cur_off);
        cur_cross = |cur_mask[7:4];
        word_base = {addr_q[31:2], 2'b00};
    end

    // Next-state logic and request capture.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    type_d  = req_type;
                    addr_d  = req_addr;
                    data_d  = req_data;
                    err_d   = req_drop;
                    state_d = req_drop ? StFin : StWr0;
                end
            end
            StWr0: begin
                if (mem_ready) begin
                    state_d = cur_cross ? StWr1 : StFin;
                end
            end
            StWr1: begin
                if (mem_ready) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side and completion outputs, all decoded from registered state.
    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wbe   = 4'b0000;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state_q)
            StWr0: begin
                mem_valid = 1'b1;
                mem_addr  = word_base;
                mem_wbe   = cur_mask[3:0];
                mem_wdata = data_q << {cur_off, 3'b000};
            end
            StWr1: begin
                mem_valid = 1'b1;
                // Wraps naturally at the top of the address space.
                mem_addr  = word_base + 32'd4;
                mem_wbe   = cur_mask[7:4];
                mem_wdata = data_q >> (6'd32 - {1'b0, cur_off, 3'b000});
            end
            StFin: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            type_q  <= TypeSb;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    logic unused_type_sh;
    assign unused_type_sh = (TypeSh == TypeSw);

endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: one split-enabled and one split-disabled instance,
// a select flag steers requests to one of them and picks which outputs are observed.
module tb_store_align;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_ready;
    logic        sel;

    logic        a_ready, a_mvalid, a_done, a_err;
    logic [31:0] a_maddr, a_wdata;
    logic [3:0]  a_wbe;
    logic        b_ready, b_mvalid, b_done, b_err;
    logic [31:0] b_maddr, b_wdata;
    logic [3:0]  b_wbe;
    logic        a_req_valid, b_req_valid;

    logic        o_ready, o_mvalid, o_done, o_err;
    logic [31:0] o_maddr, o_wdata;
    logic [3:0]  o_wbe;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign a_req_valid = req_valid && !sel;
    assign b_req_valid = req_valid && sel;
    assign o_ready  = sel ? b_ready  : a_ready;
    assign o_mvalid = sel ? b_mvalid : a_mvalid;
    assign o_done   = sel ? b_done   : a_done;
    assign o_err    = sel ? b_err    : a_err;
    assign o_maddr  = sel ? b_maddr  : a_maddr;
    assign o_wdata  = sel ? b_wdata  : a_wdata;
    assign o_wbe    = sel ? b_wbe    : a_wbe;

    store_align #(.SPLIT_EN(1)) u_split (
        .CLK(CLK), .RST(RST), .req_valid(a_req_valid), .req_ready(a_ready),
        .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .mem_valid(a_mvalid), .mem_ready(mem_ready), .mem_addr(a_maddr),
        .mem_wdata(a_wdata), .mem_wbe(a_wbe), .done(a_done), .err(a_err)
    );

    store_align #(.SPLIT_EN(0)) u_nosplit (
        .CLK(CLK), .RST(RST), .req_valid(b_req_valid), .req_ready(b_ready),
        .req_type(req_type), .req_addr(req_addr), .req_data(req_data),
        .mem_valid(b_mvalid), .mem_ready(mem_ready), .mem_addr(b_maddr),
        .mem_wdata(b_wdata), .mem_wbe(b_wbe), .done(b_done), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        check("ready_before_req", {31'b0, o_ready}, 32'd1);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_data  = d;
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    // Check the write currently presented, then move past the next edge.
    task automatic expect_write(input string tag, input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd);
        check({tag, "_valid"}, {31'b0, o_mvalid}, 32'd1);
        check({tag, "_addr"}, o_maddr, a);
        check({tag, "_wbe"}, {28'b0, o_wbe}, {28'b0, be});
        check({tag, "_wdata"}, o_wdata, wd);
        check({tag, "_nodone"}, {31'b0, o_done}, 32'd0);
        @(negedge CLK);
    endtask

    task automatic expect_done(input string tag, input logic e);
        check({tag, "_done"}, {31'b0, o_done}, 32'd1);
        check({tag, "_err"}, {31'b0, o_err}, {31'b0, e});
        check({tag, "_fin_mvalid"}, {31'b0, o_mvalid}, 32'd0);
        check({tag, "_fin_wbe"}, {28'b0, o_wbe}, 32'd0);
        check({tag, "_fin_ready"}, {31'b0, o_ready}, 32'd0);
        @(negedge CLK);
        check({tag, "_done_gone"}, {31'b0, o_done}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, o_ready}, 32'd1);
    endtask

    initial begin
        RST       = 1'b1;
        req_valid = 1'b0;
        req_type  = 2'b00;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        mem_ready = 1'b1;
        sel       = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_ready", {31'b0, o_ready}, 32'd0);
        check("rst_mvalid", {31'b0, o_mvalid}, 32'd0);
        check("rst_addr", o_maddr, 32'h0);
        check("rst_wdata", o_wdata, 32'h0);
        check("rst_wbe", {28'b0, o_wbe}, 32'd0);
        check("rst_done", {31'b0, o_done}, 32'd0);
        check("rst_err", {31'b0, o_err}, 32'd0);
        RST = 1'b0;
        #1;
        check("rst_release_ready", {31'b0, o_ready}, 32'd1);

        // Byte store into the top lane.
        issue(2'b00, 32'h0000_1003, 32'h0000_00AB);
        expect_write("sb3", 32'h0000_1000, 4'b1000, 32'hAB00_0000);
        expect_done("sb3", 1'b0);

        // Byte store into lane 1.
        issue(2'b00, 32'h0000_5001, 32'h0000_005A);
        expect_write("sb1", 32'h0000_5000, 4'b0010, 32'h0000_5A00);
        expect_done("sb1", 1'b0);

        // Half store into upper half, no crossing.
        issue(2'b01, 32'h0000_4002, 32'h0000_CAFE);
        expect_write("sh2", 32'h0000_4000, 4'b1100, 32'hCAFE_0000);
        expect_done("sh2", 1'b0);

        // Aligned word.
        issue(2'b10, 32'h0000_6000, 32'hDEAD_BEEF);
        expect_write("sw0", 32'h0000_6000, 4'b1111, 32'hDEAD_BEEF);
        expect_done("sw0", 1'b0);

        // Word crossing at offset 2: split into two writes.
        issue(2'b10, 32'h0000_2002, 32'h1122_3344);
        expect_write("sw2_w0", 32'h0000_2000, 4'b1100, 32'h3344_0000);
        expect_write("sw2_w1", 32'h0000_2004, 4'b0011, 32'h0000_1122);
        expect_done("sw2", 1'b0);

        // Half crossing with backpressure on the first write.
        mem_ready = 1'b0;
        issue(2'b01, 32'h0000_3003, 32'h0000_BEEF);
        for (int i = 0; i < 3; i++) begin
            check("sh3_hold_valid", {31'b0, o_mvalid}, 32'd1);
            check("sh3_hold_addr", o_maddr, 32'h0000_3000);
            check("sh3_hold_wbe", {28'b0, o_wbe}, 32'd8);
            check("sh3_hold_wdata", o_wdata, 32'hEF00_0000);
            @(negedge CLK);
        end
        mem_ready = 1'b1;
        expect_write("sh3_w0", 32'h0000_3000, 4'b1000, 32'hEF00_0000);
        expect_write("sh3_w1", 32'h0000_3004, 4'b0001, 32'h0000_00BE);
        expect_done("sh3", 1'b0);

        // Crossing at the top of the address space wraps to zero.
        issue(2'b10, 32'hFFFF_FFFF, 32'h1122_3344);
        expect_write("wrap_w0", 32'hFFFF_FFFC, 4'b1000, 32'h4400_0000);
        expect_write("wrap_w1", 32'h0000_0000, 4'b0111, 32'h0011_2233);
        expect_done("wrap", 1'b0);

        // Reserved type is dropped.
        issue(2'b11, 32'h0000_0010, 32'h1234_5678);
        expect_done("rsv", 1'b1);

        // Split-disabled instance: crossing word is dropped, aligned word is written.
        sel = 1'b1;
        issue(2'b10, 32'h0000_2002, 32'h1122_3344);
        expect_done("nosplit_cross", 1'b1);
        issue(2'b10, 32'h0000_2000, 32'h1122_3344);
        expect_write("nosplit_al", 32'h0000_2000, 4'b1111, 32'h1122_3344);
        expect_done("nosplit_al", 1'b0);
        issue(2'b00, 32'h0000_2003, 32'h0000_0077);
        expect_write("nosplit_sb", 32'h0000_2000, 4'b1000, 32'h7700_0000);
        expect_done("nosplit_sb", 1'b0);
        sel = 1'b0;

        // Reset during a stalled second write abandons it silently.
        issue(2'b10, 32'h0000_2002, 32'h1122_3344);
        expect_write("rst_w0", 32'h0000_2000, 4'b1100, 32'h3344_0000);
        mem_ready = 1'b0;
        check("rst_in_wr1", {31'b0, o_mvalid}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_abort_mvalid", {31'b0, o_mvalid}, 32'd0);
        check("rst_abort_done", {31'b0, o_done}, 32'd0);
        check("rst_abort_err", {31'b0, o_err}, 32'd0);
        check("rst_abort_ready", {31'b0, o_ready}, 32'd0);
        RST = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_abort_ready_back", {31'b0, o_ready}, 32'd1);
        @(negedge CLK);
        check("rst_abort_no_late_done", {31'b0, o_done}, 32'd0);
        check("rst_abort_idle_mvalid", {31'b0, o_mvalid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_align.md
STORE_ALIGN -- requirements
Module: store_align

Interface
REQ-001 Parameter SPLIT_EN, default 1, meaning: 1 = word-crossing stores split into two memory writes; 0 = word-crossing stores rejected with error.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_type  input  2  00 SB, 01 SH, 10 SW, 11 reserved.
REQ-007 req_addr  input  32  byte address of store.
REQ-008 req_data  input  32  store data, right-justified (SB uses [7:0], SH uses [15:0]).
REQ-009 mem_valid  output  1  word write request to data memory.
REQ-010 mem_ready  input  1  memory accepts the current write.
REQ-011 mem_addr  output  32  word-aligned byte address, [1:0] always 00.
REQ-012 mem_wdata  output  32  lane-positioned write data.
REQ-013 mem_wbe  output  4  byte enables, bit i = byte lane i.
REQ-014 done  output  1  one-cycle pulse: request finished.
REQ-015 err  output  1  one-cycle pulse coincident with done: request dropped, no memory write.

Function
REQ-016 The block SHALL implement states IDLE, WR0, WR1, FIN.
REQ-017 req_ready SHALL be 1 only in IDLE with RST low; a request is accepted when req_valid & req_ready and SHALL be registered (type, addr, data).
REQ-018 Size n = 1/2/4 bytes for SB/SH/SW; off = addr[1:0]; 8-bit mask M = ((1<<n)-1) << off; low mask = M[3:0], high mask = M[7:4]; cross = |M[7:4].
REQ-019 On accept: reserved type, or cross with SPLIT_EN=0, -> FIN with error flag; otherwise -> WR0.
REQ-020 WR0: mem_valid=1, mem_addr={addr[31:2],2'b00}, mem_wbe=low mask, mem_wdata=(data << 8*off) truncated to 32 bits.
REQ-021 WR1: mem_valid=1, mem_addr={addr[31:2],2'b00}+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000), mem_wbe=high mask, mem_wdata=data >> 8*(4-off).
REQ-022 In WR0/WR1 all mem_* outputs SHALL remain stable while mem_ready=0; advance only on mem_valid & mem_ready.
REQ-023 WR0 handshake -> WR1 if cross, else FIN; WR1 handshake -> FIN.
REQ-024 FIN: done=1 for exactly one cycle, err=1 only for dropped requests; unconditionally -> IDLE.
REQ-025 Outside WR0/WR1: mem_valid=0, mem_wbe=0000, mem_addr and mem_wdata=0.
REQ-026 Latency with mem_ready=1: accept at cycle t, first write t+1, second write (if cross) t+2, done at the cycle after last write; dropped request done/err at t+1.
REQ-027 A new request SHALL NOT be accepted in the same cycle done is asserted; req_ready returns the cycle after FIN.
REQ-028 Aligned SW (off=0) and non-crossing SB/SH SHALL produce exactly one memory write.

Reset
REQ-029 RST high at a clock edge SHALL force IDLE on the next cycle from any state, abandoning any in-flight write without done/err.
REQ-030 Reset values: req_ready=0 while RST high, then 1; mem_valid=0, mem_wbe=0000, mem_addr=0, mem_wdata=0, done=0, err=0.

Verification
REQ-031 SB addr 0x00001003 data 0x000000AB, mem_ready=1 -> one write addr 0x00001000 wbe 1000 wdata 0xAB000000; done next cycle, err=0.
REQ-032 SW addr 0x00002002 data 0x11223344 -> write 0x00002000 wbe 1100 wdata 0x33440000, then 0x00002004 wbe 0011 wdata 0x00001122; done after second.
REQ-033 SH addr 0x00003003 data 0x0000BEEF, mem_ready low 3 cycles -> outputs held at 0x00003000 wbe 1000 wdata 0xEF000000; then 0x00003004 wbe 0001 wdata 0x000000BE.
REQ-034 SW addr 0xFFFFFFFF data 0x11223344 -> 0xFFFFFFFC wbe 1000 wdata 0x44000000, then 0x00000000 wbe 0111 wdata 0x00112233.
REQ-035 req_type 11; and SPLIT_EN=0 with SW at 0x00002002 -> mem_valid never asserted, done=1 and err=1 one cycle after accept.
REQ-036 RST asserted during WR1 with mem_ready=0 -> next cycle mem_valid=0, no done; req_ready=1 the cycle after RST deasserts.
